glm_update: RTL and testbench
=============================

// Module: glm_update
// PURPOSE
//  Model-update stage consuming the scalar dot results produced by the dot stage.
//  Per sample: pops one dot scalar from FIFO_dot and scales it by the step size.
//  Then re-streams the sample's feature lines and read-modify-writes the model BRAM: model -= scale*x.
//  Optionally forwards each updated model line to FIFO_modelforward, feeding the next dot stage.
// PARAMETERS
//  VALUES_PER_LINE  16  32-bit signed fixed-point lanes per 512-bit line
//  FRAC_BITS        16  fractional bits of all operands (Q16.16)
//  PIPE_DEPTH        2  cycles from line issue (re) to model write (we)
// PORTS
//  clk                input   1     clock
//  resetn             input   1     reset, asynchronous, active-low
//  op_start           input   1     start pulse, sampled only in IDLE
//  op_done            output  1     1-cycle pulse, operation complete
//  regs               input   32xNUM_REGS  [3][15:0]=num_lines, [3][16]=fwd_en, [4][15:0]=model_off,
//                                   [5][15:0]=num_samples, [6]=step (Q16.16)
//  FIFO_dot           fifo_read   intf  scalar dot results, rdata[31:0], rvalid 1 cycle after re
//  FIFO_input         fifo_read   intf  feature lines, 512 b, rvalid 1 cycle after re
//  MEM_model          bram_read   intf  model read port, rvalid 1 cycle after re
//  MEM_model_wr       bram_write  intf  model write port (we, waddr, wdata)
//  FIFO_modelforward  fifo_write  intf  updated model lines; almostfull = <4 free entries
// BEHAVIOUR
//  Reset (async, resetn=0): state IDLE; op_done, all re/we strobes, counters = 0; in-flight lines dropped.
//  All re/we strobes default low each cycle; asserted only as listed below.
//  States:
//   IDLE:   on op_start latch regs. If num_samples==0 -> DONE. Else -> FETCH_DOT.
//   FETCH_DOT:
//     - If !FIFO_dot.empty: pulse FIFO_dot.re once, then wait for rvalid.
//     - On rvalid, latch d -> SCALE.
//   SCALE:  scale = sat32((d*step)>>>FRAC_BITS).
//     - 64-bit signed product; arithmetic shift (floor).
//     - If num_lines==0 -> NEXT; else -> STREAM.
//   STREAM: issue line i when all hold:
//     - !FIFO_input.empty
//     - fwd_en==0 or !FIFO_modelforward.almostfull
//     On issue, same cycle: FIFO_input.re=1, MEM_model.re=1, raddr=model_off+i (16-bit wrap); i++.
//     After line num_lines-1 is issued -> DRAIN.
//   DRAIN:  wait until in-flight count==0 -> NEXT.
//   NEXT:   sample_cnt++. If sample_cnt==num_samples -> DONE; else -> FETCH_DOT.
//           Guarantees no read-after-write hazard across samples.
//   DONE:   op_done=1 for one cycle -> IDLE.
//  Pipeline (per line; FIFO_input.rvalid and MEM_model.rvalid always coincide):
//   - Issue cycle t; data valid t+1.
//   - Lane k at t+1, registered:
//       p   = sat32((scale*x[k])>>>FRAC_BITS)
//       new = sat32(model[k]-p)
//   - t+2: MEM_model_wr.we=1, waddr = address issued at t, wdata = new.
//     If fwd_en: FIFO_modelforward.we=1 with same wdata.
//   - Writes occur in issue order; throughput 1 line/cycle when unstalled.
//  Saturation: clamp to [0x80000000, 0x7FFFFFFF] at each sat32; never wrap.
//  op_start outside IDLE is ignored. Stalls never drop or duplicate lines.
//  Dot scalars are consumed in FIFO order.
// TESTING
//  1 sample, 1 line, d=0x20000, step=0x8000, x=0x10000 all lanes, model=0x30000
//    -> write 0x20000 all lanes at model_off; op_done 1 cycle after DRAIN.
//  num_lines=4, FIFO_input empty 3 cycles between lines
//    -> re only when non-empty; writes to off..off+3 in order; op_done once.
//  fwd_en=1, almostfull held 10 cycles mid-stream
//    -> no issue while held; forward FIFO receives all lines, same data as BRAM writes.
//  scale=0x10000, x=0xFFFF0000(-1.0), model=0x7FFFFFF0
//    -> written lane 0x7FFFFFFF (saturated, no wrap).
//  num_samples=0 -> op_done exactly one pulse after start; no re/we ever asserted.
//  resetn low during STREAM with 2 lines in flight
//    -> strobes low immediately, no further writes; next op after release runs correctly.

Source files
------------

// File: rtl/glm_update_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | glm_update_if : FIFO / BRAM port bundles used by the GLM update stage     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

interface fifo_read_if #(
    parameter int WIDTH = 512
);
    logic             re;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             empty;
    modport master (output re, input rdata, input rvalid, input empty);
    modport slave  (input re, output rdata, output rvalid, output empty);
endinterface

interface bram_read_if #(
    parameter int AW = 16,
    parameter int DW = 512
);
    logic          re;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    modport master (output re, output raddr, input rdata, input rvalid);
    modport slave  (input re, input raddr, output rdata, output rvalid);
endinterface

interface bram_write_if #(
    parameter int AW = 16,
    parameter int DW = 512
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    modport master (output we, output waddr, output wdata);
    modport slave  (input we, input waddr, input wdata);
endinterface

interface fifo_write_if #(
    parameter int DW = 512
);
    logic          we;
    logic [DW-1:0] wdata;
    logic          almostfull;
    modport master (output we, output wdata, input almostfull);
    modport slave  (input we, input wdata, output almostfull);
endinterface

`default_nettype wire

// File: rtl/glm_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | glm_update : per-sample model update, model -= sat(scale * x), Q16.16     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module glm_update #(
    parameter int VALUES_PER_LINE = 16,
    parameter int FRAC_BITS       = 16,
    parameter int PIPE_DEPTH      = 2,
    parameter int NUM_REGS        = 7
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         op_start,
    output logic         op_done,
    input  logic [31:0]  regs [NUM_REGS],
    fifo_read_if.master  FIFO_dot,
    fifo_read_if.master  FIFO_input,
    bram_read_if.master  MEM_model,
    bram_write_if.master MEM_model_wr,
    fifo_write_if.master FIFO_modelforward
);

    localparam int c_LINE_W   = VALUES_PER_LINE * 32;
    localparam int c_FLIGHT_W = $clog2(PIPE_DEPTH + 1);
    localparam logic signed [63:0] c_SAT_MAX = 64'sd2147483647;
    localparam logic signed [63:0] c_SAT_MIN = -64'sd2147483648;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_DOT = 3'd1,
        S_SCALE     = 3'd2,
        S_STREAM    = 3'd3,
        S_DRAIN     = 3'd4,
        S_NEXT      = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    function automatic logic [31:0] sat32(input logic signed [63:0] v);
        if (v > c_SAT_MAX) return 32'h7FFF_FFFF;
        if (v < c_SAT_MIN) return 32'h8000_0000;
        return v[31:0];
    endfunction

    // Full 64-bit product, floor shift back to Q16.16, then clamp.
    function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] prod;
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sat32(prod >>> FRAC_BITS);
    endfunction

    state_t                r_state, w_state_nxt;
    logic [15:0]           r_num_lines, r_model_off, r_num_samples;
    logic [15:0]           r_line_cnt, r_sample_cnt;
    logic                  r_fwd_en;
    logic [31:0]           r_step, r_dot, r_scale;
    logic                  r_dot_pending;
    logic                  r_v1, r_we;
    logic [15:0]           r_a1, r_waddr;
    logic [c_LINE_W-1:0]   r_wdata;
    logic [c_LINE_W-1:0]   w_new_line;
    logic [15:0]           w_raddr;
    logic                  w_issue, w_dot_re;
    logic [c_FLIGHT_W-1:0] w_in_flight;
    logic                  w_unused;

    assign w_unused = ^{regs[0], regs[1], regs[2], regs[3][31:17], regs[4][31:16], regs[5][31:16]};

    assign w_issue = (r_state == S_STREAM) && !FIFO_input.empty &&
                     (!r_fwd_en || !FIFO_modelforward.almostfull);
    assign w_raddr = r_model_off + r_line_cnt;
    assign w_in_flight = c_FLIGHT_W'(r_v1) + c_FLIGHT_W'(r_we);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        op_done     = 1'b0;
        w_dot_re    = 1'b0;
        case (r_state)
            S_IDLE:
                if (op_start) w_state_nxt = (regs[5][15:0] == 16'd0) ? S_DONE : S_FETCH_DOT;
            S_FETCH_DOT: begin
                w_dot_re = !r_dot_pending && !FIFO_dot.empty;
                if (r_dot_pending && FIFO_dot.rvalid) w_state_nxt = S_SCALE;
            end
            S_SCALE:
                w_state_nxt = (r_num_lines == 16'd0) ? S_NEXT : S_STREAM;
            S_STREAM:
                if (w_issue && (r_line_cnt == r_num_lines - 16'd1)) w_state_nxt = S_DRAIN;
            S_DRAIN:
                if (w_in_flight == '0) w_state_nxt = S_NEXT;
            S_NEXT:
                w_state_nxt = ((r_sample_cnt + 16'd1) == r_num_samples) ? S_DONE : S_FETCH_DOT;
            S_DONE: begin
                op_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_num_lines   <= '0;
            r_model_off   <= '0;
            r_num_samples <= '0;
            r_fwd_en      <= 1'b0;
            r_step        <= '0;
            r_dot         <= '0;
            r_dot_pending <= 1'b0;
            r_scale       <= '0;
            r_line_cnt    <= '0;
            r_sample_cnt  <= '0;
            r_v1          <= 1'b0;
            r_a1          <= '0;
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
        end else begin
            r_v1 <= w_issue;
            r_a1 <= w_raddr;
            r_we <= r_v1 & FIFO_input.rvalid & MEM_model.rvalid;
            if (r_v1) begin
                r_waddr <= r_a1;
                r_wdata <= w_new_line;
            end
            case (r_state)
                S_IDLE:
                    if (op_start) begin
                        r_num_lines   <= regs[3][15:0];
                        r_fwd_en      <= regs[3][16];
                        r_model_off   <= regs[4][15:0];
                        r_num_samples <= regs[5][15:0];
                        r_step        <= regs[6];
                        r_sample_cnt  <= '0;
                    end
                S_FETCH_DOT:
                    if (w_dot_re) begin
                        r_dot_pending <= 1'b1;
                    end else if (r_dot_pending && FIFO_dot.rvalid) begin
                        r_dot         <= FIFO_dot.rdata[31:0];
                        r_dot_pending <= 1'b0;
                    end
                S_SCALE: begin
                    r_scale    <= fx_mul(r_dot, r_step);
                    r_line_cnt <= '0;
                end
                S_STREAM:
                    if (w_issue) r_line_cnt <= r_line_cnt + 16'd1;
                S_NEXT:
                    r_sample_cnt <= r_sample_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < VALUES_PER_LINE; k++) begin : g_lane
        logic [31:0] w_x, w_m, w_p;
        assign w_x = FIFO_input.rdata[k*32 +: 32];
        assign w_m = MEM_model.rdata[k*32 +: 32];
        assign w_p = fx_mul(r_scale, w_x);
        assign w_new_line[k*32 +: 32] =
            sat32($signed({{32{w_m[31]}}, w_m}) - $signed({{32{w_p[31]}}, w_p}));
    end

    assign FIFO_dot.re             = w_dot_re;
    assign FIFO_input.re           = w_issue;
    assign MEM_model.re            = w_issue;
    assign MEM_model.raddr         = w_raddr;
    assign MEM_model_wr.we         = r_we;
    assign MEM_model_wr.waddr      = r_waddr;
    assign MEM_model_wr.wdata      = r_wdata;
    assign FIFO_modelforward.we    = r_we & r_fwd_en;
    assign FIFO_modelforward.wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_glm_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_glm_update : directed vectors and sequences for glm_update            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module tb_glm_update;

    localparam int VPL = 16;
    localparam int LW  = VPL * 32;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic        op_start = 1'b0;
    logic        op_done;
    logic [31:0] regs [7];

    fifo_read_if  #(.WIDTH(32))        dot_if ();
    fifo_read_if  #(.WIDTH(LW))        in_if  ();
    bram_read_if  #(.AW(16), .DW(LW))  mr_if  ();
    bram_write_if #(.AW(16), .DW(LW))  mw_if  ();
    fifo_write_if #(.DW(LW))           fw_if  ();

    glm_update dut (
        .clk               (clk),
        .resetn            (resetn),
        .op_start          (op_start),
        .op_done           (op_done),
        .regs              (regs),
        .FIFO_dot          (dot_if),
        .FIFO_input        (in_if),
        .MEM_model         (mr_if),
        .MEM_model_wr      (mw_if),
        .FIFO_modelforward (fw_if)
    );

    always #5 clk = ~clk;

    logic [31:0]   dot_q [$];
    logic [LW-1:0] in_q [$];
    logic [LW-1:0] mem [256];
    logic [15:0]   wr_addr_q [$];
    logic [LW-1:0] wr_data_q [$];
    logic [LW-1:0] fwd_q [$];
    int gap = 0, gap_cnt = 0;
    int total = 0, bad = 0;
    int done_cnt = 0, strobe_cnt = 0, re_cnt = 0, viol_empty = 0, viol_af = 0;

    // Synchronous FIFO / BRAM models: data one cycle after the strobe.
    always @(posedge clk) begin
        logic [31:0]   d;
        logic [LW-1:0] l;
        dot_if.rvalid <= 1'b0;
        in_if.rvalid  <= 1'b0;
        mr_if.rvalid  <= 1'b0;
        if (dot_if.re && dot_q.size() > 0) begin
            d = dot_q.pop_front();
            dot_if.rdata  <= d;
            dot_if.rvalid <= 1'b1;
        end
        if (in_if.re && in_q.size() > 0) begin
            l = in_q.pop_front();
            in_if.rdata  <= l;
            in_if.rvalid <= 1'b1;
            gap_cnt = gap;
        end else if (gap_cnt > 0) begin
            gap_cnt = gap_cnt - 1;
        end
        if (mr_if.re) begin
            mr_if.rdata  <= mem[mr_if.raddr[7:0]];
            mr_if.rvalid <= 1'b1;
        end
        if (mw_if.we) begin
            mem[mw_if.waddr[7:0]] = mw_if.wdata;
            wr_addr_q.push_back(mw_if.waddr);
            wr_data_q.push_back(mw_if.wdata);
        end
        if (fw_if.we) fwd_q.push_back(fw_if.wdata);
        dot_if.empty <= (dot_q.size() == 0);
        in_if.empty  <= (in_q.size() == 0) || (gap_cnt != 0);
    end

    always @(negedge clk) begin
        if (op_done) done_cnt++;
        if (dot_if.re || in_if.re || mr_if.re || mw_if.we || fw_if.we) strobe_cnt++;
        if (in_if.re) re_cnt++;
        if (in_if.re && in_if.empty) viol_empty++;
        if (in_if.re && fw_if.almostfull && regs[3][16]) viol_af++;
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] fill(input logic [31:0] v);
        logic [LW-1:0] r;
        for (int k = 0; k < VPL; k++) r[k*32 +: 32] = v;
        return r;
    endfunction

    task automatic set_regs(input logic [15:0] nl, input logic fwd, input logic [15:0] off,
                            input logic [15:0] ns, input logic [31:0] step);
        regs[3] = {15'd0, fwd, nl};
        regs[4] = {16'd0, off};
        regs[5] = {16'd0, ns};
        regs[6] = step;
    endtask

    task automatic start_op();
        done_cnt = 0; strobe_cnt = 0; re_cnt = 0; viol_empty = 0; viol_af = 0;
        wr_addr_q.delete(); wr_data_q.delete(); fwd_q.delete();
        @(negedge clk); #1 op_start = 1'b1;
        @(negedge clk); #1 op_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (done_cnt == 0 && c < 5000) begin
            @(negedge clk); #1;
            c++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s_timeout: op_done not seen after %0d cycles, required 1 pulse", name, c);
        end
        repeat (4) @(negedge clk);
        #1;
        check({name, "_done_once"}, LW'(done_cnt), LW'(1));
    endtask

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] step;
        logic [31:0] x;
        logic [31:0] m;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]   off;
        logic [LW-1:0] e;
        int            c, held;

        vecs[0] = '{32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0003_0000, 32'h0002_0000};
        vecs[1] = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h7FFF_FFF0, 32'h7FFF_FFFF};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h8000_0005, 32'h8000_0000};
        vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0001_0000, 32'h0000_0000, 32'h8000_0001};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_8000, 32'h0001_0000, 32'h0000_0100, 32'h0000_0101};
        vecs[5] = '{32'h0003_0000, 32'h0001_0000, 32'h0000_8000, 32'h0005_0000, 32'h0003_8000};
        vecs[6] = '{32'h0003_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
        vecs[7] = '{32'hFFFE_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_0000, 32'h0004_0000};

        for (int i = 0; i < 7; i++) regs[i] = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        fw_if.almostfull = 1'b0;
        dot_if.rvalid <= 1'b0; dot_if.rdata <= '0; dot_if.empty <= 1'b1;
        in_if.rvalid  <= 1'b0; in_if.rdata  <= '0; in_if.empty  <= 1'b1;
        mr_if.rvalid  <= 1'b0; mr_if.rdata  <= '0;

        repeat (3) @(negedge clk);
        check("rst_op_done", LW'(op_done), '0);
        check("rst_strobes", LW'({dot_if.re, in_if.re, mr_if.re, mw_if.we, fw_if.we}), '0);
        #1 resetn = 1'b1;

        // Single-sample, single-line arithmetic vectors
        for (int i = 0; i < 8; i++) begin
            off = 16'(8 + i);
            mem[off[7:0]] = fill(vecs[i].m);
            dot_q.push_back(vecs[i].d);
            in_q.push_back(fill(vecs[i].x));
            set_regs(16'd1, 1'b0, off, 16'd1, vecs[i].step);
            start_op();
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d_data", i), mem[off[7:0]], fill(vecs[i].exp));
            check($sformatf("vec%0d_addr", i),
                  LW'((wr_addr_q.size() == 1) ? wr_addr_q[0] : 16'hFFFF), LW'(off));
        end

        // Four lines with 3 empty cycles between them, plus a stray op_start mid-stream
        gap = 3;
        for (int i = 0; i < 4; i++) begin
            mem[8'h20 + i] = fill(32'h0010_0000);
            for (int k = 0; k < VPL; k++) e[k*32 +: 32] = 32'((k + i) << 16);
            in_q.push_back(e);
        end
        dot_q.push_back(32'h0001_0000);
        set_regs(16'd4, 1'b0, 16'h0020, 16'd1, 32'h0001_0000);
        start_op();
        repeat (6) @(negedge clk);
        #1 op_start = 1'b1;
        @(negedge clk); #1 op_start = 1'b0;
        wait_done("gaps");
        gap = 0;
        check("gaps_re_while_empty", LW'(viol_empty), '0);
        check("gaps_nwrites", LW'(wr_addr_q.size()), LW'(4));
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < VPL; k++) e[k*32 +: 32] = 32'h0010_0000 - 32'((k + i) << 16);
            check($sformatf("gaps_addr%0d", i),
                  LW'((wr_addr_q.size() > i) ? wr_addr_q[i] : 16'hFFFF), LW'(16'h20 + i));
            check($sformatf("gaps_data%0d", i), mem[8'h20 + i], e);
        end

        // Forwarding enabled with almostfull held for 10 cycles mid-stream
        for (int i = 0; i < 6; i++) begin
            mem[8'h50 + i] = fill(32'h0020_0000);
            for (int k = 0; k < VPL; k++) e[k*32 +: 32] = 32'h8000 * 32'(k + 1 + i);
            in_q.push_back(e);
        end
        dot_q.push_back(32'h0002_0000);
        set_regs(16'd6, 1'b1, 16'h0050, 16'd1, 32'h0001_0000);
        start_op();
        c = 0;
        while (re_cnt < 2 && c < 200) begin
            @(negedge clk); #1;
            c++;
        end
        fw_if.almostfull = 1'b1;
        held = re_cnt;
        repeat (10) @(negedge clk);
        #1;
        check("fwd_no_issue_while_af", LW'(re_cnt), LW'(held));
        fw_if.almostfull = 1'b0;
        wait_done("fwd");
        check("fwd_re_while_af", LW'(viol_af), '0);
        check("fwd_nwrites", LW'(wr_data_q.size()), LW'(6));
        check("fwd_nforward", LW'(fwd_q.size()), LW'(6));
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < VPL; k++) e[k*32 +: 32] = 32'h0020_0000 - 32'((k + 1 + i) << 16);
            check($sformatf("fwd_bram%0d", i), mem[8'h50 + i], e);
            check($sformatf("fwd_fifo%0d", i), (fwd_q.size() > i) ? fwd_q[i] : '0, e);
        end

        // Two samples on the same line: dot scalars in FIFO order, second reads first's write
        mem[8'h30] = fill(32'h0010_0000);
        dot_q.push_back(32'h0001_0000);
        dot_q.push_back(32'h0002_0000);
        in_q.push_back(fill(32'h0001_0000));
        in_q.push_back(fill(32'h0003_0000));
        set_regs(16'd1, 1'b0, 16'h0030, 16'd2, 32'h0001_0000);
        start_op();
        wait_done("two_samples");
        check("two_samples_nwrites", LW'(wr_addr_q.size()), LW'(2));
        check("two_samples_data", mem[8'h30], fill(32'h0009_0000));

        // num_lines == 0: dot is still consumed, nothing written
        dot_q.push_back(32'h0001_0000);
        set_regs(16'd0, 1'b0, 16'h0040, 16'd1, 32'h0001_0000);
        start_op();
        wait_done("zero_lines");
        check("zero_lines_nwrites", LW'(wr_addr_q.size()), '0);
        check("zero_lines_dot_popped", LW'(dot_q.size()), '0);

        // num_samples == 0: only the done pulse
        set_regs(16'd3, 1'b1, 16'h0060, 16'd0, 32'h0001_0000);
        start_op();
        wait_done("zero_samples");
        check("zero_samples_strobes", LW'(strobe_cnt), '0);

        // Reset with two lines in flight, then a clean operation
        for (int i = 0; i < 6; i++) begin
            mem[8'h70 + i] = fill(32'h0010_0000);
            in_q.push_back(fill(32'h0001_0000));
        end
        dot_q.push_back(32'h0001_0000);
        set_regs(16'd6, 1'b0, 16'h0070, 16'd1, 32'h0001_0000);
        start_op();
        c = 0;
        while (re_cnt < 3 && c < 200) begin
            @(negedge clk); #1;
            c++;
        end
        resetn = 1'b0;
        #1;
        check("arst_strobes", LW'({dot_if.re, in_if.re, mr_if.re, mw_if.we, fw_if.we}), '0);
        repeat (3) @(negedge clk);
        check("arst_nwrites", LW'(wr_addr_q.size()), '0);
        check("arst_mem", mem[8'h70], fill(32'h0010_0000));
        dot_q.delete();
        in_q.delete();
        gap_cnt = 0;
        #1 resetn = 1'b1;
        repeat (2) @(negedge clk);
        mem[8'h78] = fill(32'h0003_0000);
        dot_q.push_back(32'h0002_0000);
        in_q.push_back(fill(32'h0001_0000));
        set_regs(16'd1, 1'b0, 16'h0078, 16'd1, 32'h0000_8000);
        start_op();
        wait_done("after_rst");
        check("after_rst_data", mem[8'h78], fill(32'h0002_0000));
        check("after_rst_nwrites", LW'(wr_addr_q.size()), LW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
